// File: rtl/seq_mul_cla.sv
// Iterative unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH through a chain of 4-bit CLA slices.
// Optional zero-operand early termination is enabled by defining SEQ_MUL_EARLY_TERM_EN.
module seq_mul_cla #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int NSL = WIDTH / 4;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // 4-bit carry-lookahead slice: returns {cout, sum}
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Partial-product add: slice carry-out ripples into the next slice's carry-in
  always_comb begin : add_chain
    logic v_c;
    w_addend = r_mq[0] ? r_mcand : '0;
    w_sum    = '0;
    v_c      = 1'b0;
    for (int i = 0; i < NSL; i++) begin
      {v_c, w_sum[4*i +: 4]} = cla4(r_acc[4*i +: 4], w_addend[4*i +: 4], v_c);
    end
    w_cout = v_c;
  end

  // Control FSM and datapath registers with registered busy/done/product
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand <= multiplicand;
            r_mq    <= multiplier;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
`ifdef SEQ_MUL_EARLY_TERM_EN
            if ((multiplicand == '0) || (multiplier == '0)) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              product <= '0;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
`else
            r_state <= S_RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
`endif
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        S_RUN: begin
          // The adder carry becomes the top accumulator bit as the pair shifts right
          r_acc   <= {w_cout, w_sum[WIDTH-1:1]};
          r_mq    <= {w_sum[0], r_mq[WIDTH-1:1]};
          r_carry <= w_cout;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {w_cout, w_sum, r_mq[WIDTH-1:1]};
          end else begin
            r_state <= S_RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_cla.sv
// Self-checking bench for seq_mul_cla (WIDTH=8): directed corner cases plus randomized operands
// against a plain-arithmetic reference; honours SEQ_MUL_EARLY_TERM_EN for expected latency.
module tb_seq_mul_cla;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total_cnt;
  int bad_cnt;
  bit mon_en;

  seq_mul_cla #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // busy and done must never be high together
  always @(negedge clk) begin
    if (mon_en) check_val("busy_done_excl", 64'(busy & done), 64'd0);
  end

  function automatic bit is_short(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
    return (a == '0) || (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // One operation from an idle DUT: latency, busy length, result, pulse width, hold
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int nbusy;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] expp;
    expp = (2*W)'(a) * (2*W)'(b);
    prev = product;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = W'($urandom); multiplier = W'($urandom);
    lat = 1; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      check_val("prod_hold_run", 64'(product), 64'(prev));
      @(posedge clk); #1;
      lat++;
    end
    check_val("done_seen", 64'(done), 64'd1);
    check_val("latency", 64'(lat), is_short(a, b) ? 64'd1 : 64'(W + 1));
    check_val("busy_cycles", 64'(nbusy), is_short(a, b) ? 64'd0 : 64'(W));
    check_val("product", 64'(product), 64'(expp));
    @(posedge clk); #1;
    check_val("done_pulse", 64'(done), 64'd0);
    check_val("prod_hold", 64'(product), 64'(expp));
  endtask

  initial begin
    int lat;
    int dones;
    int first_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    total_cnt = 0; bad_cnt = 0; mon_en = 1'b0;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_prod", 64'(product), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // directed corners
    run_op(8'd13, 8'd11);
    run_op(8'd255, 8'd255);
    run_op(8'd0, 8'd200);
    run_op(8'd200, 8'd0);
    run_op(8'd1, 8'd1);
    run_op(8'd255, 8'd1);
    run_op(8'd128, 8'd128);

    // start held high with operands changing mid-run: next op accepted in DONE
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd7; multiplier = 8'd9;
    @(posedge clk); #1;
    multiplicand = 8'hFF; multiplier = 8'hFF;
    lat = 1; dones = 0; first_done = 0;
    while (dones < 2 && lat < 60) begin
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_done = lat;
          check_val("b2b_prod1", 64'(product), 64'd63);
          check_val("b2b_lat1", 64'(lat), 64'(W + 1));
        end else begin
          check_val("b2b_prod2", 64'(product), 64'd65025);
          check_val("b2b_gap", 64'(lat - first_done), 64'(W + 1));
          start = 1'b0;
        end
      end
      if (dones < 2) begin
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    check_val("b2b_dones", 64'(dones), 64'd2);
    @(posedge clk); #1;
    check_val("b2b_idle", 64'(busy | done), 64'd0);

    // reset during RUN aborts with no done pulse
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd100; multiplier = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_prod", 64'(product), 64'd0);
    dones = 0;
    repeat (12) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check_val("abort_nodone", 64'(dones), 64'd0);
    run_op(8'd100, 8'd3);

    // randomized operands, occasionally forced to zero
    for (int k = 0; k < 25; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      run_op(ra, rb);
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
